clock_div_ctrl: RTL and testbench

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

---
 rtl/clock_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_clock_div_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable clock divider with a registered, glitch-free
// divided clock. The half-period divisor is staged through a valid/ready port
// and only applied at a high->low boundary, so a high phase is never cut
// short or stretched. Stopping is graceful: a high phase always completes.
module clock_div_ctrl #(
   parameter int unsigned DIV_WIDTH        = 16,
   parameter int unsigned DEFAULT_DIV_HALF = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 cfg_valid,
   input  logic [DIV_WIDTH-1:0] cfg_div_half,
   output logic                 cfg_ready,
   output logic                 clk_div,
   output logic                 tick,
   output logic                 running
);

   // Reset divisor; a zero half-period would never terminate, so clamp to 1.
   localparam logic [DIV_WIDTH-1:0] RESET_DIV =
      (DEFAULT_DIV_HALF == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV_HALF);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STOP_PEND = 2'd2
   } state_e;

   state_e               state_q,   state_d;
   logic                 clk_div_q, clk_div_d;
   logic                 tick_q,    tick_d;
   logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
   logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
   logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
   logic                 pend_vld_q, pend_vld_d;

   logic                 terminal;
   logic                 transfer;
   logic                 apply;

   // cur_div is never 0, so cur_div-1 cannot underflow and cnt stays in range.
   assign terminal = (cnt_q == (cur_div_q - DIV_WIDTH'(1)));
   assign transfer = cfg_valid && !pend_vld_q;

   // Next-state, counter, divided-clock and divisor-staging logic.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch is inferred.
      state_d    = state_q;
      clk_div_d  = clk_div_q;
      tick_d     = 1'b0;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      pend_vld_d = pend_vld_q;
      apply      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            clk_div_d = 1'b0;
            cnt_d     = '0;
            apply     = pend_vld_q;
            if (en) state_d = ST_RUN;
         end

         ST_RUN, ST_STOP_PEND: begin
            if (terminal) begin
               clk_div_d = !clk_div_q;
               cnt_d     = '0;
               tick_d    = !clk_div_q;
               // A staged divisor only takes effect as the clock falls.
               apply     = clk_div_q && pend_vld_q;
            end else begin
               cnt_d = cnt_q + DIV_WIDTH'(1);
            end

            if (state_q == ST_RUN) begin
               if (!en) begin
                  if (!clk_div_q) begin
                     // Low phase: stop immediately; IDLE keeps the clock low.
                     state_d   = ST_IDLE;
                     cnt_d     = '0;
                     clk_div_d = 1'b0;
                     tick_d    = 1'b0;
                     apply     = 1'b0;
                  end else if (terminal) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_STOP_PEND;
                  end
               end
            end else begin
               // clk_div is high throughout STOP_PEND, so terminal means a fall.
               if (en)            state_d = ST_RUN;
               else if (terminal) state_d = ST_IDLE;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clk_div_d = 1'b0;
            cnt_d     = '0;
         end
      endcase

      // apply needs pend_vld=1 and transfer needs pend_vld=0: never both.
      if (apply) begin
         cur_div_d  = pend_div_q;
         pend_vld_d = 1'b0;
      end
      if (transfer) begin
         pend_div_d = (cfg_div_half == '0) ? DIV_WIDTH'(1) : cfg_div_half;
         pend_vld_d = 1'b1;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         clk_div_q  <= 1'b0;
         tick_q     <= 1'b0;
         cnt_q      <= '0;
         cur_div_q  <= RESET_DIV;
         pend_div_q <= RESET_DIV;
         pend_vld_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q    <= state_d;
         clk_div_q  <= clk_div_d;
         tick_q     <= tick_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   assign cfg_ready = !pend_vld_q;
   assign clk_div   = clk_div_q;
   assign tick      = tick_q;
   assign running   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: one task per scenario, each comparing the
// divided clock, tick, running and cfg_ready against hand-derived waveforms.
module tb_clock_div_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en, cfg_valid;
   logic [15:0] cfg_div_half;
   logic        cfg_ready, clk_div, tick, running;

   // Narrow instance to reach the top of the divisor range quickly.
   logic        en3, cfg_valid3;
   logic [2:0]  cfg_div3;
   logic        cfg_ready3, clk_div3, tick3, running3;

   int n_checks = 0;
   int n_fail   = 0;

   clock_div_ctrl #(.DIV_WIDTH(16), .DEFAULT_DIV_HALF(1)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .cfg_valid(cfg_valid),
      .cfg_div_half(cfg_div_half), .cfg_ready(cfg_ready), .clk_div(clk_div),
      .tick(tick), .running(running)
   );

   clock_div_ctrl #(.DIV_WIDTH(3), .DEFAULT_DIV_HALF(0)) dut_w3 (
      .clk(clk), .reset_n(reset_n), .en(en3), .cfg_valid(cfg_valid3),
      .cfg_div_half(cfg_div3), .cfg_ready(cfg_ready3), .clk_div(clk_div3),
      .tick(tick3), .running(running3)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; en = 1'b1;
      step(); step();
      n_checks++; if (clk_div !== 1'b0) begin n_fail++; $display("FAIL reset_clk_div: got %b expected 0", clk_div); end
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
      n_checks++; if (cfg_ready3 !== 1'b1 || running3 !== 1'b0) begin n_fail++; $display("FAIL reset_w3: got ready=%b running=%b expected 1/0", cfg_ready3, running3); end
      reset_n = 1'b1;
   endtask

   // Default divisor 1 with en high from release: clk/2, tick every other cycle.
   task automatic test_div1_default();
      for (int k = 0; k < 8; k++) begin
         step();
         n_checks++; if (clk_div !== 1'(k % 2)) begin n_fail++; $display("FAIL div1_clk_div[%0d]: got %b expected %b", k, clk_div, 1'(k % 2)); end
         n_checks++; if (tick !== 1'(k % 2)) begin n_fail++; $display("FAIL div1_tick[%0d]: got %b expected %b", k, tick, 1'(k % 2)); end
         n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL div1_running[%0d]: got %b expected 1", k, running); end
      end
      en = 1'b0;
      step();
      n_checks++; if (running !== 1'b0 || clk_div !== 1'b0) begin n_fail++; $display("FAIL div1_stop: got running=%b clk_div=%b expected 0/0", running, clk_div); end
   endtask

   // Load 3 in IDLE, then run: rise 3 edges after en is sampled, 3/3 waveform.
   task automatic test_load_idle();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_before: got %b expected 1", cfg_ready); end
      cfg_valid = 1'b1; cfg_div_half = 16'd3;
      step();
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_staged: got %b expected 0", cfg_ready); end
      cfg_valid = 1'b0;
      step();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_applied: got %b expected 1", cfg_ready); end
      en = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         step();
         n_checks++; if (clk_div !== 1'((k / 3) % 2)) begin n_fail++; $display("FAIL div3_clk_div[%0d]: got %b expected %b", k, clk_div, 1'((k / 3) % 2)); end
         n_checks++; if (tick !== 1'(k % 6 == 3)) begin n_fail++; $display("FAIL div3_tick[%0d]: got %b expected %b", k, tick, 1'(k % 6 == 3)); end
      end
   endtask

   // Continues from the div-3 run, one cycle into a high phase: write 5.
   task automatic test_change_mid_high();
      cfg_valid = 1'b1; cfg_div_half = 16'd5;
      step(); // edge 11
      n_checks++; if (cfg_ready !== 1'b0 || clk_div !== 1'b1) begin n_fail++; $display("FAIL chg_staged: got ready=%b clk_div=%b expected 0/1", cfg_ready, clk_div); end
      cfg_valid = 1'b0;
      step(); // edge 12: high phase ends after its original 3 cycles
      n_checks++; if (clk_div !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL chg_fall: got clk_div=%b ready=%b expected 0/1", clk_div, cfg_ready); end
      for (int k = 13; k <= 22; k++) begin
         step();
         n_checks++; if (clk_div !== 1'(k >= 17 && k <= 21)) begin n_fail++; $display("FAIL div5_clk_div[%0d]: got %b expected %b", k, clk_div, 1'(k >= 17 && k <= 21)); end
         n_checks++; if (tick !== 1'(k == 17)) begin n_fail++; $display("FAIL div5_tick[%0d]: got %b expected %b", k, tick, 1'(k == 17)); end
      end
      en = 1'b0;
      step();
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL chg_stop: got running=%b expected 0", running); end
   endtask

   // Divisor 4: graceful stop from the high phase, then a cancelled stop.
   task automatic test_stop();
      cfg_valid = 1'b1; cfg_div_half = 16'd4;
      step();
      cfg_valid = 1'b0;
      step();
      en = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         step();
         n_checks++; if (clk_div !== 1'(k >= 4)) begin n_fail++; $display("FAIL stop_rise[%0d]: got %b expected %b", k, clk_div, 1'(k >= 4)); end
      end
      en = 1'b0;
      for (int k = 5; k <= 7; k++) begin
         step();
         n_checks++; if (clk_div !== 1'b1 || running !== 1'b1) begin n_fail++; $display("FAIL stop_hold[%0d]: got clk_div=%b running=%b expected 1/1", k, clk_div, running); end
      end
      step();
      n_checks++; if (clk_div !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL stop_done: got clk_div=%b running=%b expected 0/0", clk_div, running); end

      en = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         step();
         n_checks++; if (clk_div !== 1'((k / 4) % 2)) begin n_fail++; $display("FAIL resume_clk_div[%0d]: got %b expected %b", k, clk_div, 1'((k / 4) % 2)); end
         n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running[%0d]: got %b expected 1", k, running); end
         if (k == 4) en = 1'b0;
         if (k == 5) en = 1'b1;
      end
      en = 1'b0;
      step();
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL resume_stop: got running=%b expected 0", running); end
   endtask

   // Zero clamps to 1; a second value held on cfg_valid is refused while staged.
   task automatic test_zero_and_hold();
      cfg_valid = 1'b1; cfg_div_half = 16'd0;
      step();
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL zero_staged: got %b expected 0", cfg_ready); end
      cfg_div_half = 16'd6;
      step();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready: got %b expected 1", cfg_ready); end
      cfg_valid = 1'b0;
      en = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         step();
         n_checks++; if (clk_div !== 1'(k % 2)) begin n_fail++; $display("FAIL zero_clk_div[%0d]: got %b expected %b", k, clk_div, 1'(k % 2)); end
      end
      en = 1'b0;
      step();
      n_checks++; if (clk_div !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL zero_stop: got clk_div=%b running=%b expected 0/0", clk_div, running); end
   endtask

   // Async reset mid high phase with a staged divisor; restart uses the default.
   task automatic test_reset_mid();
      cfg_valid = 1'b1; cfg_div_half = 16'd4;
      step();
      cfg_valid = 1'b0;
      step();
      en = 1'b1;
      for (int k = 0; k <= 5; k++) step();
      n_checks++; if (clk_div !== 1'b1) begin n_fail++; $display("FAIL rmid_high: got %b expected 1", clk_div); end
      cfg_valid = 1'b1; cfg_div_half = 16'd2;
      step();
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_staged: got %b expected 0", cfg_ready); end
      cfg_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (clk_div !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got clk_div=%b tick=%b expected 0/0", clk_div, tick); end
      n_checks++; if (cfg_ready !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got ready=%b running=%b expected 1/0", cfg_ready, running); end
      en = 1'b0;
      step(); step();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if (clk_div !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL rmid_idle[%0d]: got clk_div=%b running=%b expected 0/0", k, clk_div, running); end
      end
      en = 1'b1;
      step();
      n_checks++; if (clk_div !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL rmid_start: got clk_div=%b running=%b expected 0/1", clk_div, running); end
      step();
      n_checks++; if (clk_div !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL rmid_default: got clk_div=%b tick=%b expected 1/1", clk_div, tick); end
      en = 1'b0;
   endtask

   // 3-bit instance: DEFAULT_DIV_HALF=0 acts as 1, then the maximum divisor 7.
   task automatic test_narrow_max();
      en3 = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         step();
         n_checks++; if (clk_div3 !== 1'(k % 2)) begin n_fail++; $display("FAIL w3_def_clk_div[%0d]: got %b expected %b", k, clk_div3, 1'(k % 2)); end
      end
      en3 = 1'b0;
      step();
      n_checks++; if (running3 !== 1'b0) begin n_fail++; $display("FAIL w3_stop: got %b expected 0", running3); end
      cfg_valid3 = 1'b1; cfg_div3 = 3'd7;
      step();
      cfg_valid3 = 1'b0;
      step();
      en3 = 1'b1;
      for (int k = 0; k <= 21; k++) begin
         step();
         n_checks++; if (clk_div3 !== 1'((k / 7) % 2)) begin n_fail++; $display("FAIL w3_max_clk_div[%0d]: got %b expected %b", k, clk_div3, 1'((k / 7) % 2)); end
         n_checks++; if (tick3 !== 1'(k % 14 == 7)) begin n_fail++; $display("FAIL w3_max_tick[%0d]: got %b expected %b", k, tick3, 1'(k % 14 == 7)); end
      end
      en3 = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div_half = '0;
      en3 = 1'b0; cfg_valid3 = 1'b0; cfg_div3 = '0;
      #1;
      test_reset();
      test_div1_default();
      test_load_idle();
      test_change_mid_high();
      test_stop();
      test_zero_and_hold();
      test_reset_mid();
      test_narrow_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
